// File: rtl/imem_loader_pkg.sv
// rtl/imem_loader_pkg.sv - shared state encoding and sizing constants for the instruction-memory loader
package imem_loader_pkg;

    // Loader FSM states, in frame order
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_LO = 3'd1,
        ST_LEN_HI = 3'd2,
        ST_DATA   = 3'd3,
        ST_CSUM   = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } state_e;

    localparam int DEPTH_DEFAULT   = 256;
    localparam int TIMEOUT_DEFAULT = 1000;

    // Word address width; the core indexes instruction memory with address[9:2]
    localparam int ADDR_W = 8;

    // States in which a frame is being received and bytes are accepted
    function automatic logic is_receiving(input state_e s);
        return (s == ST_LEN_LO) || (s == ST_LEN_HI) || (s == ST_DATA) || (s == ST_CSUM);
    endfunction

endpackage

// File: rtl/imem_loader_timeout.sv
// rtl/imem_loader_timeout.sv - idle-cycle counter that flags when a receive stalls too long
module imem_loader_timeout #(
    parameter int TIMEOUT = 1000
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    // This idle cycle would bring the count to TIMEOUT; a clear (byte accept) on the same cycle wins
    assign expire = count && !clear && (cnt_q == W'(TIMEOUT - 1));

    // Idle counter: cleared on accept/restart, advances on idle receive cycles
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (count && (cnt_q != W'(TIMEOUT))) begin
            cnt_q <= cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - receives a length/payload/checksum frame and writes it into instruction memory
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int DEPTH   = DEPTH_DEFAULT,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              core_rst,
    output logic              core_enable,
    output logic              busy,
    output logic              done,
    output logic              error
);

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q;
    logic [15:0]       len_q;
    logic [ADDR_W-1:0] word_idx_q;
    logic [1:0]        byte_idx_q;
    logic [23:0]       asm_q;
    logic [7:0]        csum_q;

    logic              rx_ready_q, imem_we_q, core_rst_q, core_enable_q;
    logic              busy_q, done_q, error_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_wdata_q;

    logic              accept, restart, expire, last_word;
    logic [15:0]       rx_len;

    assign accept    = rx_valid && rx_ready_q;
    assign restart   = start && ((state_q == ST_IDLE) || (state_q == ST_DONE) || (state_q == ST_ERR));
    assign rx_len    = {rx_data, len_lo_q};
    assign last_word = ((16'(word_idx_q) + 16'd1) == len_q);

    imem_loader_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (clk),
        .rst    (rst),
        .clear  (accept || restart),
        .count  (is_receiving(state_q)),
        .expire (expire)
    );

    // Next-state decision; a byte accept always takes precedence over a timeout
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) state_d = ST_LEN_LO;
            end
            ST_LEN_LO: begin
                if (accept)      state_d = ST_LEN_HI;
                else if (expire) state_d = ST_ERR;
            end
            ST_LEN_HI: begin
                if (accept) begin
                    if ((rx_len == 16'd0) || (rx_len > 16'(DEPTH))) state_d = ST_ERR;
                    else                                            state_d = ST_DATA;
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_DATA: begin
                if (accept) begin
                    if ((byte_idx_q == 2'd3) && last_word) state_d = ST_CSUM;
                end else if (expire) begin
                    state_d = ST_ERR;
                end
            end
            ST_CSUM: begin
                if (accept)      state_d = (rx_data == csum_q) ? ST_DONE : ST_ERR;
                else if (expire) state_d = ST_ERR;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register, frame datapath and registered outputs derived from the next state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            len_lo_q      <= '0;
            len_q         <= '0;
            word_idx_q    <= '0;
            byte_idx_q    <= '0;
            asm_q         <= '0;
            csum_q        <= '0;
            rx_ready_q    <= 1'b0;
            imem_we_q     <= 1'b0;
            imem_addr_q   <= '0;
            imem_wdata_q  <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            error_q       <= 1'b0;
            core_rst_q    <= 1'b1;
            core_enable_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            rx_ready_q    <= is_receiving(state_d);
            busy_q        <= is_receiving(state_d);
            done_q        <= (state_d == ST_DONE);
            error_q       <= (state_d == ST_ERR);
            core_rst_q    <= (state_d != ST_DONE);
            core_enable_q <= (state_d == ST_DONE);
            imem_we_q     <= 1'b0;

            if (restart) begin
                word_idx_q <= '0;
                byte_idx_q <= '0;
                asm_q      <= '0;
                csum_q     <= '0;
            end

            if (accept) begin
                case (state_q)
                    ST_LEN_LO: len_lo_q <= rx_data;
                    ST_LEN_HI: len_q    <= rx_len;
                    ST_DATA: begin
                        csum_q     <= csum_q ^ rx_data;
                        byte_idx_q <= byte_idx_q + 2'd1;
                        case (byte_idx_q)
                            2'd0: asm_q[7:0]   <= rx_data;
                            2'd1: asm_q[15:8]  <= rx_data;
                            2'd2: asm_q[23:16] <= rx_data;
                            default: begin
                                imem_we_q    <= 1'b1;
                                imem_addr_q  <= word_idx_q;
                                imem_wdata_q <= {rx_data, asm_q};
                                word_idx_q   <= word_idx_q + 1'b1;
                            end
                        endcase
                    end
                    default: ;
                endcase
            end
        end
    end

    assign rx_ready    = rx_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign error       = error_q;
    assign core_rst    = core_rst_q;
    assign core_enable = core_enable_q;

endmodule
